// File: rtl/tern_serial_add_ctrl_if.sv
// rtl/tern_serial_add_ctrl_if.sv - start/busy/done handshake and operand/result bus of tern_serial_add_ctrl
// Optional feature macro: TERN_SUB_EN (adds the sub request bit).
// Signals:
//   start        request, sampled by the controller only when idle
//   a, b         operands, 2 bits per trit, trit k at [2k+1:2k] (00=0, 01=1, 10=2)
//   cin          carry into trit 0
//   sub          (TERN_SUB_EN only) select A-B
//   busy, done   controller status; done is a one-cycle pulse
//   sum, cout    result trits and carry out of the top trit
//   err          an operand carried the illegal code 11
// Modports: master = requester side, slave = controller side.
interface tern_serial_add_ctrl_if #(
   parameter int NPAIRS = 4
);
   logic                  start;
   logic [4*NPAIRS-1:0]   a;
   logic [4*NPAIRS-1:0]   b;
   logic                  cin;
`ifdef TERN_SUB_EN
   logic                  sub;
`endif
   logic                  busy;
   logic                  done;
   logic [4*NPAIRS-1:0]   sum;
   logic                  cout;
   logic                  err;

`ifdef TERN_SUB_EN
   modport master (output start, a, b, cin, sub, input busy, done, sum, cout, err);
   modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, err);
`else
   modport master (output start, a, b, cin, input busy, done, sum, cout, err);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout, err);
`endif
endinterface

// File: rtl/tern_serial_add_ctrl.sv
// rtl/tern_serial_add_ctrl.sv - serial sequencer driving one 2-trit carry-lookahead ternary adder slice
// Optional feature macro: TERN_SUB_EN (A-B via trit complement and forced carry-in).
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   bus     tern_serial_add_ctrl_if.slave: start/a/b/cin[/sub] in, busy/done/sum/cout/err out
// Parameter:
//   NPAIRS  number of 2-trit pairs per operand (>= 1)
module tern_serial_add_ctrl #(
   parameter int NPAIRS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   tern_serial_add_ctrl_if.slave  bus
);
   localparam int W  = 4 * NPAIRS;
   localparam int CW = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
   localparam logic [CW-1:0] LAST_PAIR = CW'(NPAIRS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          carry_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  sum_q;
   logic          cout_q;
   logic          done_q;
   logic          err_q;

   // Operand clean-up at latch time: illegal 11 trits become 0 and flag err.
   logic [W-1:0]  a_clean;
   logic [W-1:0]  b_clean;
   logic [W-1:0]  b_eff;
   logic          illegal;
   logic          carry_init;

   always_comb begin
      a_clean = bus.a;
      b_clean = bus.b;
      illegal = 1'b0;
      for (int k = 0; k < 2*NPAIRS; k++) begin
         if (bus.a[2*k +: 2] == 2'b11) begin
            a_clean[2*k +: 2] = 2'b00;
            illegal           = 1'b1;
         end
         if (bus.b[2*k +: 2] == 2'b11) begin
            b_clean[2*k +: 2] = 2'b00;
            illegal           = 1'b1;
         end
      end
   end

`ifdef TERN_SUB_EN
   // A-B = A + (3^n-1-B) + 1: per-trit complement 2-d, carry-in forced to 1.
   always_comb begin
      b_eff = b_clean;
      if (bus.sub) begin
         for (int k = 0; k < 2*NPAIRS; k++) begin
            b_eff[2*k +: 2] = 2'd2 - b_clean[2*k +: 2];
         end
      end
   end
   assign carry_init = bus.sub ? 1'b1 : bus.cin;
`else
   assign b_eff      = b_clean;
   assign carry_init = bus.cin;
`endif

   // Adder slice for the pair selected by cnt.
   logic [CW+1:0] idx;
   logic [1:0]    a0, a1, b0, b1;
   logic [2:0]    ab0, ab1, t0, t1;
   logic          g0, p0, g1, p1, c1;
   logic [1:0]    s_lo, s_hi;
   logic          slice_cout;

   assign idx = {cnt, 2'b00};

   always_comb begin
      a0  = a_q[idx +: 2];
      a1  = a_q[idx + 2 +: 2];
      b0  = b_q[idx +: 2];
      b1  = b_q[idx + 2 +: 2];
      ab0 = {1'b0, a0} + {1'b0, b0};
      ab1 = {1'b0, a1} + {1'b0, b1};
      // Generate: the trit pair already overflows; propagate: it sums to 2,
      // so an incoming carry ripples through.
      g0  = (ab0 >= 3'd3);
      p0  = (ab0 == 3'd2);
      g1  = (ab1 >= 3'd3);
      p1  = (ab1 == 3'd2);
      c1  = g0 | (p0 & carry_q);
      t0  = ab0 + {2'b00, carry_q};
      t1  = ab1 + {2'b00, c1};
      s_lo = 2'((t0 >= 3'd3) ? (t0 - 3'd3) : t0);
      s_hi = 2'((t1 >= 3'd3) ? (t1 - 3'd3) : t1);
      slice_cout = g1 | (p1 & g0) | (p1 & p0 & carry_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  a_q     <= a_clean;
                  b_q     <= b_eff;
                  err_q   <= illegal;
                  carry_q <= carry_init;
                  cnt     <= '0;
                  sum_q   <= '0;
                  cout_q  <= 1'b0;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               sum_q[idx +: 4] <= {s_hi, s_lo};
               carry_q         <= slice_cout;
               cnt             <= cnt + CW'(1);
               if (cnt == LAST_PAIR) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               // Registered outputs: cout and the done pulse appear on the
               // cycle after this edge, together with the idle state.
               cout_q <= carry_q;
               done_q <= 1'b1;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = (state == S_RUN) || (state == S_DONE);
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.err  = err_q;
endmodule
